uart_rx_dma: RTL and testbench

//  Receive-side sequencer that sits between the UART byte receiver and the memory write port.

---
 rtl/uart_rx_dma.sv | 198 +++++++++++++++++++
 tb/tb_uart_rx_dma.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_dma.sv
`timescale 1ns/1ps
// uart_rx_dma
//   Receive-side sequencer between a UART byte receiver and a memory write port.
//   Received bytes are buffered in a small FIFO, packed little-endian into 32-bit
//   words and written with a req/ack handshake into a ring of BUF_WORDS words that
//   starts at BASE_ADDR. A partially filled word is flushed after TIMEOUT idle
//   cycles (TIMEOUT = 0 disables the flush). Dropped bytes set a sticky overflow
//   flag, and every completed write gives a one-cycle irq pulse.
//
// Ports
//   i_clk        system clock, all logic on the rising edge
//   i_reset      asynchronous, active-high reset
//   i_enable     1 = accept new bytes; 0 = drop new bytes, keep draining the FIFO
//   i_rx_valid   one-cycle strobe, i_rx_data holds a received byte
//   i_rx_data    received byte
//   i_ovf_clr    one-cycle pulse that clears o_overflow
//   o_mem_req    write request, held until i_mem_ack
//   o_mem_addr   byte address BASE_ADDR + 4*o_wr_index (zero while idle)
//   o_mem_wdata  packed word, byte k in bits [8k+7:8k]
//   o_mem_wstrb  byte-lane enables, bit k = lane k valid
//   i_mem_ack    write accepted at this edge (only looked at while o_mem_req = 1)
//   o_wr_index   ring slot of the next write
//   o_overflow   sticky, a byte was dropped because the FIFO was full
//   o_irq        one-cycle pulse the cycle after each completed write
module uart_rx_dma #(
    parameter logic [31:0] BASE_ADDR  = 32'h0040_0100,
    parameter int          BUF_WORDS  = 16,
    parameter int          FIFO_DEPTH = 8,
    parameter int          TIMEOUT    = 1000
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_enable,
    input  logic                         i_rx_valid,
    input  logic [7:0]                   i_rx_data,
    input  logic                         i_ovf_clr,
    output logic                         o_mem_req,
    output logic [31:0]                  o_mem_addr,
    output logic [31:0]                  o_mem_wdata,
    output logic [3:0]                   o_mem_wstrb,
    input  logic                         i_mem_ack,
    output logic [$clog2(BUF_WORDS)-1:0] o_wr_index,
    output logic                         o_overflow,
    output logic                         o_irq
);

    localparam int          IDX_W    = $clog2(BUF_WORDS);
    localparam int          PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic {S_COLLECT, S_WRITE} state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [7:0]           r_fifo [FIFO_DEPTH];
    logic [PTR_W:0]       r_wptr;
    logic [PTR_W:0]       r_rptr;
    logic [1:0]           r_lane;
    logic [3:0]           r_wstrb;
    logic [31:0]          r_wdata;
    logic [31:0]          r_tmo;
    logic [IDX_W-1:0]     r_wr_index;
    logic                 r_overflow;
    logic                 r_irq;

    logic [PTR_W:0]       w_count;
    logic                 w_empty;
    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_ack;
    logic                 w_mem_req;
    logic                 w_tmo_expired;
    logic [7:0]           w_rd_byte;

    // ---- byte FIFO status
    // Pointers carry one extra bit so full and empty are distinguishable.
    assign w_count   = r_wptr - r_rptr;
    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (w_count == FULL_CNT);
    assign w_push    = i_rx_valid & i_enable;
    // A pop in the same cycle frees the slot the push lands in, so a full FIFO
    // still accepts the byte.
    assign w_accept  = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;
    assign w_rd_byte = r_fifo[r_rptr[PTR_W-1:0]];

    // Only a started word (lane != 0) with nothing left to pop can time out.
    assign w_tmo_expired = (TIMEOUT != 0) && (r_lane != 2'd0) && w_empty &&
                           (r_tmo == TMO_LAST);

    // ---- sequencer: next state and handshake
    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_mem_req    = 1'b0;
        w_ack        = 1'b0;
        case (r_state)
            S_COLLECT: begin
                w_pop = ~w_empty;
                if (w_pop && (r_lane == 2'd3)) begin
                    w_state_next = S_WRITE;
                end else if (w_tmo_expired) begin
                    w_state_next = S_WRITE;
                end
            end
            S_WRITE: begin
                w_mem_req = 1'b1;
                if (i_mem_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = S_COLLECT;
                end
            end
            default: w_state_next = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ---- FIFO storage (data only, no reset needed)
    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_fifo[r_wptr[PTR_W-1:0]] <= i_rx_data;
        end
    end

    // ---- pointers, word packing, timeout, ring index, flags
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_lane     <= 2'd0;
            r_wstrb    <= 4'd0;
            r_wdata    <= 32'd0;
            r_tmo      <= 32'd0;
            r_wr_index <= '0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end

            // A drop in the same cycle as a clear keeps the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                r_overflow <= 1'b0;
            end

            r_irq <= w_ack;

            if (w_ack) begin
                r_wr_index <= r_wr_index + 1'b1;
                r_lane     <= 2'd0;
                r_wstrb    <= 4'd0;
                r_wdata    <= 32'd0;
                r_tmo      <= 32'd0;
            end else if (w_pop) begin
                r_wdata[{r_lane, 3'b000} +: 8] <= w_rd_byte;
                r_wstrb[r_lane]                <= 1'b1;
                r_lane                         <= r_lane + 2'd1;
                r_tmo                          <= 32'd0;
            end else if (r_state == S_COLLECT) begin
                if (r_lane == 2'd0) begin
                    r_tmo <= 32'd0;
                end else if (w_empty) begin
                    r_tmo <= r_tmo + 32'd1;
                end
            end
        end
    end

    // ---- outputs
    // The address is only driven while a request is up so the idle bus reads zero.
    assign o_mem_req   = w_mem_req;
    assign o_mem_addr  = w_mem_req ?
                         (BASE_ADDR + {{(30-IDX_W){1'b0}}, r_wr_index, 2'b00}) : 32'd0;
    assign o_mem_wdata = r_wdata;
    assign o_mem_wstrb = r_wstrb;
    assign o_wr_index  = r_wr_index;
    assign o_overflow  = r_overflow;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_uart_rx_dma.sv
`timescale 1ns/1ps
module tb_uart_rx_dma;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        ovf_clr = 1'b0;
    logic        mem_ack = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [3:0]  wr_index;
    logic        overflow;
    logic        irq;

    // second instance with the idle flush disabled
    logic        nt_rx_valid = 1'b0;
    logic [7:0]  nt_rx_data = 8'd0;
    logic        nt_mem_req;
    logic [31:0] nt_mem_addr;
    logic [31:0] nt_mem_wdata;
    logic [3:0]  nt_mem_wstrb;
    logic [3:0]  nt_wr_index;
    logic        nt_overflow;
    logic        nt_irq;

    int checks = 0;
    int errors = 0;

    uart_rx_dma #(.BASE_ADDR(32'h0040_0100), .BUF_WORDS(16), .FIFO_DEPTH(8), .TIMEOUT(1000)) dut (
        .i_clk(clk), .i_reset(reset), .i_enable(enable), .i_rx_valid(rx_valid),
        .i_rx_data(rx_data), .i_ovf_clr(ovf_clr), .o_mem_req(mem_req),
        .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_wstrb(mem_wstrb),
        .i_mem_ack(mem_ack), .o_wr_index(wr_index), .o_overflow(overflow), .o_irq(irq)
    );

    uart_rx_dma #(.BASE_ADDR(32'h0040_0100), .BUF_WORDS(16), .FIFO_DEPTH(8), .TIMEOUT(0)) dut_nt (
        .i_clk(clk), .i_reset(reset), .i_enable(1'b1), .i_rx_valid(nt_rx_valid),
        .i_rx_data(nt_rx_data), .i_ovf_clr(1'b0), .o_mem_req(nt_mem_req),
        .o_mem_addr(nt_mem_addr), .o_mem_wdata(nt_mem_wdata), .o_mem_wstrb(nt_mem_wstrb),
        .i_mem_ack(1'b0), .o_wr_index(nt_wr_index), .o_overflow(nt_overflow), .o_irq(nt_irq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "simulation time limit");
    end

    typedef struct {
        int          n;       // bytes to send
        logic [31:0] bytes;   // byte k in [8k+7:8k]
        int          gap;     // idle cycles after each byte
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        rx_valid = 1'b0;
        mem_ack  = 1'b0;
        ovf_clr  = 1'b0;
        enable   = 1'b1;
        reset    = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Wait for a request, check it, hold for ack_delay cycles, ack, check irq.
    task automatic expect_write(input string name, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [3:0] wstrb,
                                input int ack_delay);
        int n = 0;
        while (mem_req !== 1'b1 && n < 3000) begin
            tick();
            n++;
        end
        chk({name, " req"}, 32'(mem_req), 32'd1);
        if (mem_req !== 1'b1) return;
        chk({name, " addr"}, mem_addr, addr);
        chk({name, " wdata"}, mem_wdata, wdata);
        chk({name, " wstrb"}, 32'(mem_wstrb), 32'(wstrb));
        if (ack_delay > 0) begin
            repeat (ack_delay) tick();
            chk({name, " held req"}, 32'(mem_req), 32'd1);
            chk({name, " held wdata"}, mem_wdata, wdata);
            chk({name, " held addr"}, mem_addr, addr);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        chk({name, " irq"}, 32'(irq), 32'd1);
        chk({name, " req drop"}, 32'(mem_req), 32'd0);
        tick();
        chk({name, " irq end"}, 32'(irq), 32'd0);
    endtask

    initial begin : main
        int seen;

        vecs[0] = '{n:4, bytes:32'h44332211, gap:19, addr:32'h0040_0100, wdata:32'h44332211, wstrb:4'hF};
        vecs[1] = '{n:4, bytes:32'hEFBEADDE, gap:0,  addr:32'h0040_0104, wdata:32'hEFBEADDE, wstrb:4'hF};
        vecs[2] = '{n:2, bytes:32'h0000BBAA, gap:0,  addr:32'h0040_0108, wdata:32'h0000BBAA, wstrb:4'h3};
        vecs[3] = '{n:1, bytes:32'h0000005A, gap:3,  addr:32'h0040_010C, wdata:32'h0000005A, wstrb:4'h1};
        vecs[4] = '{n:3, bytes:32'h00030201, gap:5,  addr:32'h0040_0110, wdata:32'h00030201, wstrb:4'h7};
        vecs[5] = '{n:4, bytes:32'h80FF0100, gap:1,  addr:32'h0040_0114, wdata:32'h80FF0100, wstrb:4'hF};

        // reset state
        tick();
        chk("rst req", 32'(mem_req), 32'd0);
        chk("rst addr", mem_addr, 32'd0);
        chk("rst wdata", mem_wdata, 32'd0);
        chk("rst wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst wr_index", 32'(wr_index), 32'd0);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst irq", 32'(irq), 32'd0);
        reset = 1'b0;
        tick();

        // table of words
        for (int i = 0; i < 6; i++) begin
            logic [31:0] b;
            b = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n; k++) begin
                send_byte(b[8*k +: 8]);
                repeat (vecs[i].gap) tick();
            end
            expect_write($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, i % 3);
            chk($sformatf("vec%0d wr_index", i), 32'(wr_index), 32'(i + 1));
        end

        // 4th byte popped -> request on the following cycle
        do_reset();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        chk("lat4 req early", 32'(mem_req), 32'd0);
        tick();
        chk("lat4 req", 32'(mem_req), 32'd1);
        expect_write("lat4", 32'h0040_0100, 32'h04030201, 4'hF, 0);

        // idle flush exactly TIMEOUT cycles after the last pop
        do_reset();
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (1000) tick();
        chk("tmo req early", 32'(mem_req), 32'd0);
        tick();
        chk("tmo req", 32'(mem_req), 32'd1);
        expect_write("tmo", 32'h0040_0100, 32'h0000BBAA, 4'h3, 2);

        // TIMEOUT = 0 never flushes
        nt_rx_valid = 1'b1; nt_rx_data = 8'hAA; tick();
        nt_rx_data = 8'hBB; tick();
        nt_rx_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 2500; c++) begin
            tick();
            if (nt_mem_req === 1'b1) seen++;
        end
        chk("notmo req cycles", 32'(seen), 32'd0);
        chk("notmo wr_index", 32'(nt_wr_index), 32'd0);

        // ring wrap over 17 words
        do_reset();
        for (int w = 0; w < 17; w++) begin
            for (int k = 0; k < 4; k++) send_byte(8'(4 * w + k));
            expect_write($sformatf("wrap%0d", w), 32'h0040_0100 + 32'(4 * (w % 16)),
                         {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 4'hF, 0);
        end
        chk("wrap wr_index", 32'(wr_index), 32'd1);

        // overflow while the write is stalled, set wins over clear
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'(i);
            ovf_clr  = (i == 14);
            tick();
            if (i == 12) chk("ovf before drop", 32'(overflow), 32'd0);
        end
        rx_valid = 1'b0;
        ovf_clr  = 1'b0;
        chk("ovf set wins", 32'(overflow), 32'd1);
        repeat (186) tick();
        chk("ovf stall req", 32'(mem_req), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf clr", 32'(overflow), 32'd0);
        expect_write("ovf w0", 32'h0040_0100, 32'h04030201, 4'hF, 0);
        expect_write("ovf w1", 32'h0040_0104, 32'h08070605, 4'hF, 0);
        expect_write("ovf w2", 32'h0040_0108, 32'h0C0B0A09, 4'hF, 0);
        seen = 0;
        for (int c = 0; c < 1500; c++) begin
            tick();
            if (mem_req === 1'b1) seen++;
        end
        chk("ovf no extra write", 32'(seen), 32'd0);
        chk("ovf wr_index", 32'(wr_index), 32'd3);

        // full FIFO, push and pop on the same edge
        do_reset();
        for (int i = 1; i <= 12; i++) send_byte(8'(i));
        repeat (3) tick();
        chk("samepp req", 32'(mem_req), 32'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'h0D;
        tick();
        rx_valid = 1'b0;
        chk("samepp overflow", 32'(overflow), 32'd0);
        expect_write("samepp w1", 32'h0040_0104, 32'h08070605, 4'hF, 1);
        expect_write("samepp w2", 32'h0040_0108, 32'h0C0B0A09, 4'hF, 0);
        expect_write("samepp w3", 32'h0040_010C, 32'h0000000D, 4'h1, 0);
        chk("samepp overflow end", 32'(overflow), 32'd0);

        // enable low mid-word: new bytes dropped, partial word still flushes
        do_reset();
        send_byte(8'h01);
        send_byte(8'h02);
        enable = 1'b0;
        send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
        expect_write("enable", 32'h0040_0100, 32'h00000201, 4'h3, 0);
        chk("enable overflow", 32'(overflow), 32'd0);
        enable = 1'b1;

        // reset in the middle of a write
        do_reset();
        send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
        tick();
        chk("rstw req before", 32'(mem_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rstw req", 32'(mem_req), 32'd0);
        chk("rstw wr_index", 32'(wr_index), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
        expect_write("rstw after", 32'h0040_0100, 32'h04030201, 4'hF, 0);
        chk("rstw wr_index after", 32'(wr_index), 32'd1);

        // randomized stream against a byte-queue model
        begin : rnd
            logic [7:0] q[$];
            int nb;
            do_reset();
            nb = $urandom_range(30, 60);
            for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
            fork
                begin
                    for (int i = 0; i < nb; i++) begin
                        send_byte(q[i]);
                        repeat ($urandom_range(2, 40)) tick();
                    end
                end
                begin
                    for (int w = 0; w < (nb + 3) / 4; w++) begin
                        logic [31:0] ew;
                        logic [3:0]  es;
                        ew = 32'd0;
                        es = 4'd0;
                        for (int k = 0; k < 4; k++) begin
                            if (4 * w + k < nb) begin
                                ew[8*k +: 8] = q[4*w + k];
                                es[k] = 1'b1;
                            end
                        end
                        expect_write($sformatf("rand%0d", w), 32'h0040_0100 + 32'(4 * (w % 16)),
                                     ew, es, $urandom_range(0, 4));
                    end
                end
            join
            chk("rand overflow", 32'(overflow), 32'd0);
            chk("rand wr_index", 32'(wr_index), 32'(((nb + 3) / 4) % 16));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
